// File: rtl/mul_share_arb_pkg.sv
// Shared types and constants for the shared iterative Booth multiplier.
package mul_share_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Booth pair {b[i], b[i-1]} encodings that need an add/subtract.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage : mul_share_pkg

// File: rtl/mul_share_arb_if.sv
// Two-requester / one-response bus of the shared Booth multiplier.
interface mul_share_arb_if
  import mul_share_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic               req0_valid;
  logic               req0_ready;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic               req1_valid;
  logic               req1_ready;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [2*WIDTH-1:0] rsp_p;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_p
  );

endinterface : mul_share_arb_if

// File: rtl/mul_share_arb_booth_step.sv
// One radix-2 Booth step: conditional add/sub into the upper half, then
// an arithmetic right shift of the whole (2*WIDTH+1)-bit accumulator.
module booth_step
  import mul_share_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [1:0]       pair_i,
  output logic [2*WIDTH:0] acc_o
);

  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   hi;
  logic [WIDTH:0]   hi_sum;
  logic [2*WIDTH:0] pre;

  // Upper half is one bit wider so -2^(WIDTH-1) negates without overflow.
  always_comb begin
    a_ext = {a_i[WIDTH-1], a_i};
    hi    = acc_i[2*WIDTH:WIDTH];
    case (pair_i)
      BOOTH_ADD: hi_sum = hi + a_ext;
      BOOTH_SUB: hi_sum = hi - a_ext;
      default:   hi_sum = hi;
    endcase
    pre   = {hi_sum, acc_i[WIDTH-1:0]};
    acc_o = {pre[2*WIDTH], pre[2*WIDTH:1]};
  end

endmodule : booth_step

// File: rtl/mul_share_arb.sv
// Round-robin shared iterative Booth multiplier for two requesters.
// Optional feature: MUL_SHARE_ZERO_SKIP_EN skips RUN when an operand is zero.
module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  mul_share_arb_if.slave bus
);

  localparam int unsigned ACC_W = 2 * WIDTH + 1;
  localparam int unsigned P_W   = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic               prio_q, prio_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               id_q, id_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               e_q, e_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [P_W-1:0]     rsp_p_q, rsp_p_d;
  logic               rsp_id_q, rsp_id_d;

  logic               any_valid_c;
  logic               gnt_id_c;
  logic [WIDTH-1:0]   a_sel_c;
  logic [WIDTH-1:0]   b_sel_c;
  logic [ACC_W-1:0]   acc_step_c;

  // Round-robin grant: a lone requester wins, otherwise prio decides.
  always_comb begin
    any_valid_c = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_id_c = prio_q;
    end else begin
      gnt_id_c = bus.req1_valid;
    end
    a_sel_c = gnt_id_c ? bus.req1_a : bus.req0_a;
    b_sel_c = gnt_id_c ? bus.req1_b : bus.req0_b;
  end

  assign bus.req0_ready = (state_q == IDLE) & any_valid_c & ~gnt_id_c;
  assign bus.req1_ready = (state_q == IDLE) & any_valid_c &  gnt_id_c;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_p      = rsp_p_q;
  assign bus.rsp_id     = rsp_id_q;

  booth_step #(.WIDTH(WIDTH)) u_booth_step (
    .acc_i  (acc_q),
    .a_i    (a_q),
    .pair_i ({b_q[cnt_q], e_q}),
    .acc_o  (acc_step_c)
  );

  // Register bank with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      acc_q       <= '0;
      e_q         <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_p_q     <= '0;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      acc_q       <= acc_d;
      e_q         <= e_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_p_q     <= rsp_p_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  // Next-state and datapath control for accept / Booth steps / response hold.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    acc_d       = acc_q;
    e_d         = e_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_p_d     = rsp_p_q;
    rsp_id_d    = rsp_id_q;

    case (state_q)
      IDLE: begin
        if (any_valid_c) begin
          a_d    = a_sel_c;
          b_d    = b_sel_c;
          id_d   = gnt_id_c;
          prio_d = ~gnt_id_c;
          acc_d  = '0;
          e_d    = 1'b0;
          cnt_d  = '0;
`ifdef MUL_SHARE_ZERO_SKIP_EN
          if ((a_sel_c == '0) || (b_sel_c == '0)) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_p_d     = '0;
            rsp_id_d    = gnt_id_c;
          end else begin
            state_d = RUN;
          end
`else
          state_d = RUN;
`endif
        end
      end

      RUN: begin
        acc_d = acc_step_c;
        e_d   = b_q[cnt_q];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_p_d     = acc_step_c[P_W-1:0];
          rsp_id_d    = id_q;
        end
      end

      DONE: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule : mul_share_arb
